// File: rtl/repeat_responder_if.sv
// rtl/repeat_responder_if.sv - request/acknowledge handshake between transmitter and responder
//
// Signals:
//   tx_req  transmitter request, driven by the master
//   rx_ack  responder acknowledge, driven by the slave
interface repeat_responder_if;
    logic tx_req;
    logic rx_ack;

    modport master (output tx_req, input rx_ack);
    modport slave  (input tx_req, output rx_ack);
endinterface

// File: rtl/repeat_responder.sv
// rtl/repeat_responder.sv - holds rx_ack high for HOLD_LEN cycles per accepted request
//
// Parameters:
//   HOLD_LEN   ack cycles per accepted request (1..15)
//   CNT_W      width of rem_cnt, must hold HOLD_LEN-1
// Ports:
//   clk        clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   en         acceptance enable for new requests
//   abort      synchronous burst abort
//   clr_ovr    synchronous clear of overrun
//   link       handshake (slave side): tx_req in, rx_ack out
//   busy       high while holding the ack
//   rem_cnt    ack cycles remaining after the current one (0 when idle)
//   done       one-cycle pulse on normal burst completion
//   aborted    one-cycle pulse on abort-terminated burst
//   overrun    sticky: request dropped while busy
//   burst_cnt  completed bursts, wraps at 256
module repeat_responder #(
    parameter int HOLD_LEN = 5,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 abort,
    input  logic                 clr_ovr,
    repeat_responder_if.slave    link,
    output logic                 busy,
    output logic [CNT_W-1:0]     rem_cnt,
    output logic                 done,
    output logic                 aborted,
    output logic                 overrun,
    output logic [7:0]           burst_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rem_nxt;
    logic             done_nxt;
    logic             aborted_nxt;
    logic             ovr_set;
    logic [7:0]       burst_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem_cnt   <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            overrun   <= 1'b0;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            rem_cnt   <= rem_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
            burst_cnt <= burst_nxt;
            // A new drop wins over a coincident clear.
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem_cnt;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        ovr_set     = 1'b0;
        burst_nxt   = burst_cnt;
        case (state)
            IDLE: begin
                if (link.tx_req && en) begin
                    state_nxt = HOLD;
                    rem_nxt   = RELOAD;
                end
            end
            HOLD: begin
                if (abort) begin
                    // Abort beats completion, reload and overrun detection.
                    state_nxt   = IDLE;
                    rem_nxt     = '0;
                    aborted_nxt = 1'b1;
                end else if (rem_cnt == '0) begin
                    done_nxt  = 1'b1;
                    burst_nxt = burst_cnt + 8'd1;
                    if (link.tx_req && en) begin
                        // Back-to-back: stay in HOLD so the ack has no gap.
                        rem_nxt = RELOAD;
                    end else begin
                        state_nxt = IDLE;
                        rem_nxt   = '0;
                    end
                end else begin
                    rem_nxt = rem_cnt - CNT_W'(1);
                    ovr_set = link.tx_req;
                end
            end
            default: begin
                state_nxt = IDLE;
                rem_nxt   = '0;
            end
        endcase
    end

    assign busy        = (state == HOLD);
    assign link.rx_ack = busy;

endmodule

// File: doc/repeat_responder.md
REPEAT_RESPONDER -- requirements
Module: repeat_responder

Interface
REQ-001 Parameter HOLD_LEN, default 5, number of consecutive cycles rx_ack is held high per accepted request; legal range 1..15.
REQ-002 Parameter CNT_W, default 4, width of the remaining-cycle counter; SHALL hold HOLD_LEN-1.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  acceptance enable; new requests are accepted only while high.
REQ-006 tx_req  input  1  transmitter request, sampled on posedge clk.
REQ-007 abort  input  1  synchronous burst abort, sampled on posedge clk.
REQ-008 clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-009 rx_ack  output  1  responder acknowledge, registered.
REQ-010 busy  output  1  high while in HOLD state.
REQ-011 rem_cnt  output  CNT_W  ack cycles remaining after the current one.
REQ-012 done  output  1  one-cycle pulse on normal burst completion.
REQ-013 aborted  output  1  one-cycle pulse on abort-terminated burst.
REQ-014 overrun  output  1  sticky flag: request dropped while busy.
REQ-015 burst_cnt  output  8  count of completed bursts, wraps 255->0.

Function
REQ-016 FSM has two states, IDLE and HOLD; busy SHALL equal (state==HOLD) and rx_ack SHALL equal busy.
REQ-017 IDLE: edge sampling tx_req=1 and en=1 SHALL enter HOLD with rem_cnt=HOLD_LEN-1, so rx_ack is high at the next sampling edge (tx_req |-> ##1 rx_ack[*HOLD_LEN] holds).
REQ-018 IDLE with tx_req=1 and en=0: request ignored, no flag set.
REQ-019 HOLD, rem_cnt>0, no abort: rem_cnt decrements by 1 per edge; tx_req=1 here SHALL be dropped and set overrun.
REQ-020 HOLD, rem_cnt==0, no abort: return to IDLE, rx_ack low, done pulsed, burst_cnt incremented.
REQ-021 Back-to-back: at the rem_cnt==0 edge, tx_req=1 with en=1 SHALL reload rem_cnt=HOLD_LEN-1 and stay in HOLD; done still pulses, burst_cnt still increments, rx_ack stays high without a gap, overrun not set.
REQ-022 abort=1 in HOLD SHALL return to IDLE at that edge, rx_ack low, aborted pulsed, done not pulsed, burst_cnt unchanged; tx_req at the same edge is ignored.
REQ-023 abort=1 in IDLE has no effect; abort takes priority over every other HOLD transition.
REQ-024 en falling during HOLD SHALL NOT shorten the burst; it only blocks the back-to-back reload.
REQ-025 overrun stays set until clr_ovr=1; if set and clear coincide, set wins.
REQ-026 HOLD_LEN=1: rx_ack high for exactly one cycle; every HOLD edge is the rem_cnt==0 edge.
REQ-027 rem_cnt reads 0 in IDLE.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, rx_ack=0, busy=0, rem_cnt=0, done=0, aborted=0, overrun=0, burst_cnt=0, regardless of clk.
REQ-029 Reset asserted mid-burst SHALL drop rx_ack at once with no done or aborted pulse; after release the block accepts only new requests.

Verification
REQ-030 en=1, single tx_req pulse at edge 2 -> rx_ack high at edges 3..7, done pulse after edge 7, burst_cnt=1, overrun=0.
REQ-031 tx_req held high continuously from edge 2, en=1 -> rx_ack high with no gap from edge 3 onward, done every 5 cycles, overrun set after the first accepted edge.
REQ-032 tx_req at edge 2, abort at edge 4 -> rx_ack high at edges 3..4 only, aborted pulse, burst_cnt=0.
REQ-033 tx_req at edge 2, rst_n low between edges 4 and 5 -> rx_ack drops immediately, all outputs 0, then a new tx_req yields a full 5-cycle burst.
REQ-034 en=0 with tx_req pulse -> rx_ack stays 0; en=1 with extra tx_req at edge 4 during a burst -> overrun=1 until clr_ovr pulse, then 0.
REQ-035 HOLD_LEN=1, 256 isolated requests -> each gives one rx_ack cycle; burst_cnt wraps to 0.
